// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window frame sequencer: FSM states, the
// default counter width, the border-flag bit layout and its packing helper.
package win_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int CNT_W_DEF = 11;

    localparam int BRD_TOP   = 3;
    localparam int BRD_BOT   = 2;
    localparam int BRD_LEFT  = 1;
    localparam int BRD_RIGHT = 0;

    function automatic logic [3:0] border_flags(input logic is_top,
                                                input logic is_bot,
                                                input logic is_left,
                                                input logic is_right);
        logic [3:0] flags;
        flags            = 4'b0000;
        flags[BRD_TOP]   = is_top;
        flags[BRD_BOT]   = is_bot;
        flags[BRD_LEFT]  = is_left;
        flags[BRD_RIGHT] = is_right;
        return flags;
    endfunction

endpackage

// File: rtl/win_pos_tracker.sv
// Output-side window position tracker: turns each chain window strobe into a
// registered, tagged window and flags the last window of the frame.
module win_pos_tracker #(
    parameter int COL_NUM = 8,
    parameter int ROW_NUM = 5,
    parameter int CNT_W   = win_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             active_i,
    input  logic             lb_out_en_i,
    output logic             win_valid_o,
    output logic [CNT_W-1:0] win_row_o,
    output logic [CNT_W-1:0] win_col_o,
    output logic [3:0]       win_border_o,
    output logic             frame_done_o
);
    import win_pkg::*;

    localparam int TOT_W = 2 * CNT_W;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL_NUM - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_NUM - 1);
    localparam logic [TOT_W-1:0] WIN_LAST = TOT_W'(ROW_NUM * COL_NUM - 1);

    logic [CNT_W-1:0] out_row_q, out_row_d;
    logic [CNT_W-1:0] out_col_q, out_col_d;
    logic [TOT_W-1:0] win_cnt_q, win_cnt_d;
    logic             win_valid_q, win_valid_d;
    logic [CNT_W-1:0] win_row_q, win_row_d;
    logic [CNT_W-1:0] win_col_q, win_col_d;
    logic [3:0]       win_border_q, win_border_d;
    logic             done_q, done_d;
    logic             take_s;

    // Strobes are dropped once the frame's last window has been flagged.
    assign take_s = active_i && lb_out_en_i && !done_q;

    // Next-state for position counters and the registered window tag.
    always_comb begin
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        win_cnt_d    = win_cnt_q;
        win_valid_d  = 1'b0;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_border_d = win_border_q;
        done_d       = 1'b0;
        if (clr_i) begin
            out_row_d = '0;
            out_col_d = '0;
            win_cnt_d = '0;
        end else if (take_s) begin
            win_valid_d  = 1'b1;
            win_row_d    = out_row_q;
            win_col_d    = out_col_q;
            win_border_d = border_flags(out_row_q == '0, out_row_q == ROW_LAST,
                                        out_col_q == '0, out_col_q == COL_LAST);
            win_cnt_d    = win_cnt_q + TOT_W'(1);
            done_d       = (win_cnt_q == WIN_LAST);
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = out_row_q + CNT_W'(1);
            end else begin
                out_col_d = out_col_q + CNT_W'(1);
            end
        end else begin
            win_valid_d = 1'b0;
        end
    end

    // Tracker state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_row_q    <= '0;
            out_col_q    <= '0;
            win_cnt_q    <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_border_q <= 4'b0000;
            done_q       <= 1'b0;
        end else begin
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            win_cnt_q    <= win_cnt_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_border_q <= win_border_d;
            done_q       <= done_d;
        end
    end

    assign win_valid_o  = win_valid_q;
    assign win_row_o    = win_row_q;
    assign win_col_o    = win_col_q;
    assign win_border_o = win_border_q;
    assign frame_done_o = done_q;

endmodule

// File: rtl/frame_window_seq.sv
// Frame sequencer feeding a 3x3 line-buffer chain: forwards one raster frame,
// appends a zero padding row, and tags the windows the chain produces.
module frame_window_seq #(
    parameter int WIDTH   = 8,
    parameter int COL_NUM = 8,
    parameter int ROW_NUM = 5,
    parameter int CNT_W   = win_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             lb_valid,
    output logic [WIDTH-1:0] lb_data,
    input  logic             lb_out_en,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic [3:0]       win_border,
    output logic             busy,
    output logic             frame_done
);
    import win_pkg::*;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL_NUM - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_NUM - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] in_col_q, in_col_d;
    logic [CNT_W-1:0] in_row_q, in_row_d;
    logic [CNT_W-1:0] pad_cnt_q, pad_cnt_d;
    logic             lb_valid_q, lb_valid_d;
    logic [WIDTH-1:0] lb_data_q, lb_data_d;
    logic             clr_s;
    logic             active_s;
    logic             done_s;

    assign active_s = (state_q != IDLE);

    // Frame FSM, input raster counters and padding-row counter.
    always_comb begin
        state_d    = state_q;
        in_col_d   = in_col_q;
        in_row_d   = in_row_q;
        pad_cnt_d  = pad_cnt_q;
        lb_valid_d = 1'b0;
        lb_data_d  = '0;
        clr_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_s     = 1'b1;
                    in_col_d  = '0;
                    in_row_d  = '0;
                    pad_cnt_d = '0;
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (s_valid) begin
                    lb_valid_d = 1'b1;
                    lb_data_d  = s_data;
                    if (in_col_q == COL_LAST) begin
                        in_col_d = '0;
                        in_row_d = in_row_q + CNT_W'(1);
                        if (in_row_q == ROW_LAST) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        in_col_d = in_col_q + CNT_W'(1);
                    end
                end else begin
                    lb_valid_d = 1'b0;
                end
            end
            FLUSH: begin
                lb_valid_d = 1'b1;
                pad_cnt_d  = pad_cnt_q + CNT_W'(1);
                if (pad_cnt_q == COL_LAST) begin
                    state_d = DRAIN;
                end else begin
                    state_d = FLUSH;
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Leaving on the cycle after frame_done keeps busy high alongside it.
        state_d = done_s ? IDLE : state_d;
    end

    // Sequencer state and line-buffer write port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_col_q   <= '0;
            in_row_q   <= '0;
            pad_cnt_q  <= '0;
            lb_valid_q <= 1'b0;
            lb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_col_q   <= in_col_d;
            in_row_q   <= in_row_d;
            pad_cnt_q  <= pad_cnt_d;
            lb_valid_q <= lb_valid_d;
            lb_data_q  <= lb_data_d;
        end
    end

    win_pos_tracker #(
        .COL_NUM(COL_NUM),
        .ROW_NUM(ROW_NUM),
        .CNT_W  (CNT_W)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_s),
        .active_i    (active_s),
        .lb_out_en_i (lb_out_en),
        .win_valid_o (win_valid),
        .win_row_o   (win_row),
        .win_col_o   (win_col),
        .win_border_o(win_border),
        .frame_done_o(done_s)
    );

    assign s_ready    = (state_q == RUN);
    assign busy       = active_s;
    assign lb_valid   = lb_valid_q;
    assign lb_data    = lb_data_q;
    assign frame_done = done_s;

endmodule

// File: tb/tb_frame_window_seq.sv
// Randomized bench for frame_window_seq against a frame-level reference model
// and a simple line-buffer chain model that emits one window per strobe.
module tb_frame_window_seq;
    localparam int WIDTH   = 8;
    localparam int COL_NUM = 8;
    localparam int ROW_NUM = 5;
    localparam int CNT_W   = 11;
    localparam int TOTAL   = ROW_NUM * COL_NUM;

    logic             clk = 1'b0;
    logic             rst, start, s_valid, s_ready, lb_valid, lb_out_en;
    logic             win_valid, busy, frame_done;
    logic [WIDTH-1:0] s_data, lb_data;
    logic [CNT_W-1:0] win_row, win_col;
    logic [3:0]       win_border;

    always #5 clk = ~clk;

    frame_window_seq #(
        .WIDTH(WIDTH), .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .lb_valid(lb_valid), .lb_data(lb_data), .lb_out_en(lb_out_en),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .win_border(win_border), .busy(busy), .frame_done(frame_done)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    bit               m_active, m_wv, m_done;
    int               m_acc, m_win, m_row, m_col;
    logic [3:0]       m_brd;
    logic [WIDTH-1:0] lb_q[$];
    // chain model and run control
    int strobes, pend;
    bit rand_mode, fd_seen;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_wv = 1'b0; m_done = 1'b0;
        m_acc = 0; m_win = 0; m_row = 0; m_col = 0; m_brd = 4'b0000;
        lb_q.delete();
        strobes = 0; pend = 0;
    endtask

    task automatic cycle(input bit do_start, input bit do_rst, input bit en_force);
        bit acc, en_take, st_take, prev_done;
        logic [WIDTH-1:0] pix;
        rst       = do_rst;
        start     = do_start;
        s_valid   = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        lb_out_en = en_force;
        if (pend > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
            lb_out_en = 1'b1;
            pend--;
        end
        acc = 1'b0;
        if (do_rst) begin
            model_reset();
        end else begin
            acc     = s_valid && m_active && (m_acc < TOTAL);
            en_take = lb_out_en && m_active && !m_done;
            st_take = do_start && !m_active;
            if (acc) begin
                lb_q.push_back(s_data);
                m_acc++;
                if (m_acc == TOTAL)
                    for (int k = 0; k < COL_NUM; k++) lb_q.push_back(WIDTH'(0));
            end
            prev_done = m_done;
            m_wv = 1'b0; m_done = 1'b0;
            if (en_take) begin
                m_wv   = 1'b1;
                m_row  = m_win / COL_NUM;
                m_col  = m_win % COL_NUM;
                m_brd  = {m_row == 0, m_row == ROW_NUM - 1, m_col == 0, m_col == COL_NUM - 1};
                m_win++;
                m_done = (m_win == TOTAL);
            end
            if (st_take) begin
                m_active = 1'b1; m_acc = 0; m_win = 0;
                lb_q.delete(); strobes = 0; pend = 0;
            end else if (prev_done) begin
                m_active = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk_eq("s_ready", 32'(s_ready), 32'(m_active && (m_acc < TOTAL)));
        chk_eq("busy", 32'(busy), 32'(m_active));
        if (lb_q.size() > 0) begin
            pix = lb_q.pop_front();
            chk_eq("lb_valid", 32'(lb_valid), 32'd1);
            chk_eq("lb_data", 32'(lb_data), 32'(pix));
        end else begin
            chk_eq("lb_valid", 32'(lb_valid), 32'd0);
        end
        chk_eq("win_valid", 32'(win_valid), 32'(m_wv));
        if (m_wv) begin
            chk_eq("win_row", 32'(win_row), 32'(m_row));
            chk_eq("win_col", 32'(win_col), 32'(m_col));
            chk_eq("win_border", 32'(win_border), 32'(m_brd));
        end
        chk_eq("frame_done", 32'(frame_done), 32'(m_done));
        if (frame_done) fd_seen = 1'b1;
        if (do_rst) begin
            chk_eq("rst_lb_data", 32'(lb_data), 32'd0);
            chk_eq("rst_win_row", 32'(win_row), 32'd0);
            chk_eq("rst_win_col", 32'(win_col), 32'd0);
            chk_eq("rst_win_border", 32'(win_border), 32'd0);
            strobes = 0; pend = 0;
        end else if (lb_valid) begin
            if (strobes >= COL_NUM) pend++;
            strobes++;
        end
        if (acc) s_data = WIDTH'($urandom);
    endtask

    task automatic run_frame(input string name);
        fd_seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cycle(rand_mode && ($urandom_range(0, 15) == 0), 1'b0, 1'b0);
            if (m_done) break;
        end
        chk_eq({name, "_done_seen"}, 32'(fd_seen), 32'd1);
        chk_eq({name, "_windows"}, 32'(m_win), 32'(TOTAL));
        chk_eq({name, "_lb_drained"}, 32'(lb_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; lb_out_en = 1'b0;
        s_data = WIDTH'($urandom);
        rand_mode = 1'b0; fd_seen = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        // window strobes while idle must be ignored
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        cycle(1'b1, 1'b0, 1'b0);
        run_frame("f1_full");

        // restart one cycle after frame_done, with gaps and stray starts
        cycle(1'b0, 1'b0, 1'b0);
        rand_mode = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        run_frame("f2_gaps");

        // reset mid-frame after 17 accepted pixels
        rand_mode = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        fd_seen = 1'b0;
        for (int i = 0; i < 200 && m_acc < 17; i++) cycle(1'b0, 1'b0, 1'b0);
        chk_eq("pre_rst_accepts", 32'(m_acc), 32'd17);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk_eq("rst_no_frame_done", 32'(fd_seen), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        run_frame("f3_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_window_seq.md
# frame_window_seq

Frame sequencer for the 3x3 line-buffer window generator. Accepts a raster pixel stream over a valid/ready handshake and forwards it to the line-buffer chain. At the end of each frame it injects one zero-padding row so the final image row still produces windows. It counts the windows the chain emits and tags each one with its row, column and border flags for the downstream 3x3 FIR kernel.

## Interface
- WIDTH, 8, pixel width
- COL_NUM, 8, pixels per row (≥2)
- ROW_NUM, 5, rows per frame (≥2)
- CNT_W, 11, row/column counter width

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  frame-start pulse; honoured in IDLE only
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  upstream pixel accepted when s_valid&&s_ready
- s_data  in  WIDTH  upstream pixel, raster order
- lb_valid  out  1  write strobe into line-buffer chain
- lb_data  out  WIDTH  pixel or padding zero into chain
- lb_out_en  in  1  chain reports a valid 3x3 window this cycle
- win_valid  out  1  tagged window valid
- win_row  out  CNT_W  centre row of window
- win_col  out  CNT_W  centre column of window
- win_border  out  4  {top,bottom,left,right}
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, RUN, FLUSH, DRAIN.
- IDLE: s_ready=0, lb_valid=0. On start=1: clear all counters and go to RUN.
- RUN: s_ready=1. Each accepted pixel is registered onto lb_data with lb_valid=1. in_col advances 0..COL_NUM-1 and wraps; in_row increments on each wrap. Accepting the pixel at (ROW_NUM-1, COL_NUM-1) moves to FLUSH.
- FLUSH: s_ready=0. Drives COL_NUM consecutive cycles of lb_valid=1, lb_data=0 (bottom padding row), counted by pad_cnt. Then moves to DRAIN.
- DRAIN: s_ready=0, lb_valid=0. Waits for the remaining windows.
- Window tracking, active in RUN/FLUSH/DRAIN:
  - Each lb_out_en=1 produces one win_valid, tagged with the current out_row/out_col.
  - out_col wraps at COL_NUM-1; out_row increments on each wrap.
  - Border flags: top=(out_row==0), bottom=(out_row==ROW_NUM-1), left=(out_col==0), right=(out_col==COL_NUM-1).
- When window ROW_NUM*COL_NUM has been emitted: frame_done=1 and the state returns to IDLE.
- lb_out_en is ignored in IDLE.
- start while busy is ignored.
- s_data is not sampled when s_ready=0. Upstream must hold the pixel.

## Timing
- Reset values: state=IDLE; s_ready, lb_valid, lb_data, win_valid, win_row, win_col, win_border, busy and frame_done all 0; all counters 0.
- Handshake to line buffer: an accepted pixel appears on lb_data/lb_valid exactly 1 cycle later.
- start to first s_ready=1: 1 cycle.
- lb_out_en to win_valid and tags: 1 cycle, registered.
- frame_done asserts in the same cycle as the final win_valid. busy drops the following cycle.
- Last input accept to first FLUSH strobe: contiguous. The pixel's lb_valid is immediately followed by COL_NUM padding strobes.
- With s_valid held high, RUN lasts exactly ROW_NUM*COL_NUM cycles and FLUSH lasts COL_NUM cycles.
- Upstream gaps (s_valid=0) in RUN produce lb_valid=0 cycles. Counters hold.
- A new start is accepted at the earliest 1 cycle after frame_done.
- If lb_out_en arrives in the same cycle as a FLUSH strobe, both are processed independently.
- rst asserted mid-frame: all outputs and counters return to their reset values on the next edge. The partial frame is discarded with no frame_done. The line-buffer chain shares rst.

## Structure
- Shared package win_pkg holds:
  - state enum {IDLE, RUN, FLUSH, DRAIN}
  - CNT_W default
  - border bit indices BRD_TOP=3, BRD_BOT=2, BRD_LEFT=1, BRD_RIGHT=0
- Sub-module win_pos_tracker holds out_row/out_col, border decode, window count and the completion compare.
- The FSM, input counters and pad counter live in the top module.

## Test plan
- Full frame, s_valid held high, COL_NUM=8, ROW_NUM=5, chain model asserting lb_out_en per window:
  - 40 pixels forwarded, then 8 zero strobes
  - 40 win_valid pulses, then frame_done
- Corner tags:
  - window 0 shows win_border=4'b1010 (top, left)
  - window 7 shows 4'b1001 (top, right)
  - window 32 shows 4'b0110 (bottom, left)
  - window 39 shows 4'b0101 (bottom, right)
- Random s_valid gaps: lb_data sequence equals input sequence followed by 8 zeros; no pixel lost or duplicated; counters hold during gaps.
- start pulsed during RUN: ignored, with no counter reset. start one cycle after frame_done: a second frame completes with correct tags.
- rst asserted after 17 accepted pixels: all outputs 0 the next cycle and no frame_done. A subsequent start runs a clean 40-window frame.
- lb_out_en pulsed in IDLE: no win_valid and no count change.
